// File: rtl/sisc_mem_arb.sv
// sisc_mem_arb: round-robin arbiter for the single-port SISC memory.
// Shares the memory between instruction fetch (IF port) and data access (D port)
// for LOD/STR/SWP. The memory-side address, write data and write enable are registered.
// Each access takes a fixed MEM_LAT cycles. Completion is signalled by a one-cycle done
// pulse, and the read data is held in a per-port register.
//
// Ports:
//   clk, rst_f                 clock (posedge) and asynchronous active-low reset
//   if_req, if_addr            fetch request (level, held until done) and address
//   if_gnt, if_done, if_rdata  fetch grant, completion pulse, registered fetch data
//   d_req, d_we, d_addr,       data request (level, held until done), 1=store,
//   d_wdata                    address and store data
//   d_gnt, d_done, d_rdata     data grant, completion pulse, registered load data
//   mem_addr, mem_wdata,       registered memory address, write data, write enable
//   mem_we
//   mem_rdata                  memory read data, valid MEM_LAT cycles after mem_addr
//
// MEM_LAT must be at least 1.
module sisc_mem_arb #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned   CW      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;    // 1 = D port, 0 = IF port; doubles as last_owner
  logic          acc_we_q, acc_we_d;  // current access is a store
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          pick_d;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    acc_we_d    = acc_we_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;  // write strobe lasts only for the first ACCESS cycle
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    // D wins when it is the only requester, or on contention when IF went last.
    pick_d      = d_req && (!if_req || !owner_q);
    unique case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          state_d = StAccess;
          owner_d = pick_d;
          cnt_d   = '0;
          if (pick_d) begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_we_d    = d_we;
            acc_we_d    = d_we;
          end else begin
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            acc_we_d    = 1'b0;
          end
        end
      end
      StAccess: begin
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          if (!acc_we_q) begin
            if (owner_q) d_rdata_d  = mem_rdata;
            else         if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      acc_we_q    <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      acc_we_q    <= acc_we_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Grant and done decode straight from state so reset drops them immediately.
  always_comb begin
    if_gnt    = (state_q != StIdle) && !owner_q;
    d_gnt     = (state_q != StIdle) && owner_q;
    if_done   = (state_q == StDone) && !owner_q;
    d_done    = (state_q == StDone) && owner_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_we    = mem_we_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule
